counter_mod_chain: RTL and testbench

Parametrised multi-digit up/down counter: a chain of DIGITS modulo-RADIX digits (decimal by default) with parallel load, single-cycle increment/decrement, a selectable wrap or saturate mode, and registered carry/borrow pulses. It is the next-generation successor to the single-digit decimal counter and drives multi-digit displays, timers and cascaded counters via o_plus/o_minus.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_mod_digit.sv | 50 +++++
 rtl/counter_mod_chain.sv | 98 +++++++++
 tb/tb_counter_mod_chain.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared sizing helpers for the modulo digit chain
package counter_pkg;

    function automatic int digit_width(input int radix);
        int w;
        w = $clog2(radix);
        return (w < 1) ? 1 : w;
    endfunction

    // Bit offset of digit idx inside the packed count vector (digit 0 at bit 0).
    function automatic int digit_lsb(input int idx, input int dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/counter_mod_digit.sv
// rtl/counter_mod_digit.sv - one modulo-RADIX digit register with load, carry and borrow
module counter_mod_digit
    import counter_pkg::*;
#(
    parameter int RADIX = 10,
    parameter int DW    = digit_width(RADIX)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_load_val,
    input  logic          i_carry,
    input  logic          i_borrow,
    output logic [DW-1:0] o_value,
    output logic          o_carry,
    output logic          o_borrow,
    output logic          o_load_err
);

    localparam logic [DW-1:0] DMAX = DW'(RADIX - 1);

    logic [DW-1:0] val_d;
    logic [DW-1:0] val_q;

    // Out-of-range load fields clamp to the top digit value.
    assign o_load_err = i_load & (i_load_val > DMAX);
    assign o_carry    = i_carry & (val_q == DMAX);
    assign o_borrow   = i_borrow & (val_q == '0);
    assign o_value    = val_q;

    always_comb begin
        val_d = val_q;
        if (i_load) begin
            val_d = o_load_err ? DMAX : i_load_val;
        end else if (i_carry) begin
            val_d = (val_q == DMAX) ? '0 : val_q + 1'b1;
        end else if (i_borrow) begin
            val_d = (val_q == '0) ? DMAX : val_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

endmodule

// File: rtl/counter_mod_chain.sv
// rtl/counter_mod_chain.sv - multi-digit modulo up/down counter with wrap or saturate at the ends
module counter_mod_chain
    import counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int RADIX    = 10,
    parameter bit SATURATE = 1'b0,
    parameter int DW       = digit_width(RADIX),
    parameter int CW       = DIGITS * DW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_count,
    input  logic          i_plus,
    input  logic          i_minus,
    output logic [CW-1:0] o_count,
    output logic          o_plus,
    output logic          o_minus,
    output logic          o_zero,
    output logic          o_max,
    output logic          o_err
);

    localparam logic [DW-1:0] DMAX = DW'(RADIX - 1);

    logic [DIGITS:0]   carry;
    logic [DIGITS:0]   borrow;
    logic [DIGITS-1:0] dig_max;
    logic [DIGITS-1:0] dig_err;

    logic inc_req;
    logic dec_req;
    logic sat_up;
    logic sat_dn;

    logic plus_d,  plus_q;
    logic minus_d, minus_q;
    logic err_d,   err_q;

    assign inc_req = ~i_load & i_plus & ~i_minus;
    assign dec_req = ~i_load & i_minus & ~i_plus;

    // In saturate mode a step past either end never enters the ripple at all.
    assign sat_up = SATURATE & inc_req & o_max;
    assign sat_dn = SATURATE & dec_req & o_zero;

    assign carry[0]  = inc_req & ~sat_up;
    assign borrow[0] = dec_req & ~sat_dn;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        localparam int LSB = digit_lsb(g, DW);

        counter_mod_digit #(
            .RADIX (RADIX),
            .DW    (DW)
        ) u_digit (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_load     (i_load),
            .i_load_val (i_count[LSB +: DW]),
            .i_carry    (carry[g]),
            .i_borrow   (borrow[g]),
            .o_value    (o_count[LSB +: DW]),
            .o_carry    (carry[g+1]),
            .o_borrow   (borrow[g+1]),
            .o_load_err (dig_err[g])
        );

        assign dig_max[g] = (o_count[LSB +: DW] == DMAX);
    end

    assign o_zero = (o_count == '0);
    assign o_max  = &dig_max;

    always_comb begin
        plus_d  = carry[DIGITS] | sat_up;
        minus_d = borrow[DIGITS] | sat_dn;
        err_d   = i_load & (|dig_err);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            plus_q  <= 1'b0;
            minus_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            plus_q  <= plus_d;
            minus_q <= minus_d;
            err_q   <= err_d;
        end
    end

    assign o_plus  = plus_q;
    assign o_minus = minus_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_counter_mod_chain.sv
// tb/tb_counter_mod_chain.sv - directed bench for counter_mod_chain in wrap, saturate and radix-6 builds
module tb_counter_mod_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load, plus, minus;
    logic [7:0] cnt_in;
    logic       r_load, r_plus, r_minus;
    logic [8:0] r_cnt_in;

    logic [7:0] w_count, s_count;
    logic [8:0] r_count;
    logic w_plus, w_minus, w_zero, w_max, w_err;
    logic s_plus, s_minus, s_zero, s_max, s_err;
    logic r_plus_o, r_minus_o, r_zero, r_max, r_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_mod_chain #(.DIGITS(2), .RADIX(10), .SATURATE(1'b0)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_count(cnt_in),
        .i_plus(plus), .i_minus(minus), .o_count(w_count), .o_plus(w_plus),
        .o_minus(w_minus), .o_zero(w_zero), .o_max(w_max), .o_err(w_err)
    );

    counter_mod_chain #(.DIGITS(2), .RADIX(10), .SATURATE(1'b1)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_count(cnt_in),
        .i_plus(plus), .i_minus(minus), .o_count(s_count), .o_plus(s_plus),
        .o_minus(s_minus), .o_zero(s_zero), .o_max(s_max), .o_err(s_err)
    );

    counter_mod_chain #(.DIGITS(3), .RADIX(6), .SATURATE(1'b0)) u_r6 (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(r_load), .i_count(r_cnt_in),
        .i_plus(r_plus), .i_minus(r_minus), .o_count(r_count), .o_plus(r_plus_o),
        .o_minus(r_minus_o), .o_zero(r_zero), .o_max(r_max), .o_err(r_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_both(input logic [7:0] v);
        load = 1'b1; cnt_in = v;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 0; plus = 0; minus = 0; cnt_in = '0;
        r_load = 0; r_plus = 0; r_minus = 0; r_cnt_in = '0;
        repeat (2) cyc();
        total++; if (w_count !== 8'h00 || w_zero !== 1'b1 || w_max !== 1'b0) begin bad++; $display("FAIL reset_init count=%h zero=%b max=%b exp=00/1/0", w_count, w_zero, w_max); end
        total++; if (r_count !== 9'o000 || r_zero !== 1'b1) begin bad++; $display("FAIL reset_init_r6 count=%o zero=%b exp=000/1", r_count, r_zero); end
        #3 rst_n = 1'b1;
        load_both(8'h37);
        total++; if (w_count !== 8'h37) begin bad++; $display("FAIL reset_preload count=%h exp=37", w_count); end
        plus = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        total++; if (w_count !== 8'h00 || w_zero !== 1'b1 || w_max !== 1'b0) begin bad++; $display("FAIL reset_async count=%h zero=%b max=%b exp=00/1/0", w_count, w_zero, w_max); end
        total++; if ({w_plus, w_minus, w_err, s_plus, s_minus, s_err} !== 6'b0) begin bad++; $display("FAIL reset_pulses got=%b exp=000000", {w_plus, w_minus, w_err, s_plus, s_minus, s_err}); end
        total++; if (s_count !== 8'h00) begin bad++; $display("FAIL reset_async_sat count=%h exp=00", s_count); end
        plus = 1'b0; load = 1'b1; cnt_in = 8'h21;
        #2 rst_n = 1'b1;
        cyc();
        load = 1'b0;
        total++; if (w_count !== 8'h21) begin bad++; $display("FAIL reset_first_edge count=%h exp=21", w_count); end
    endtask

    task automatic test_carry();
        load_both(8'h19);
        plus = 1'b1; cyc(); plus = 1'b0;
        total++; if (w_count !== 8'h20 || w_plus !== 1'b0) begin bad++; $display("FAIL carry_19 count=%h plus=%b exp=20/0", w_count, w_plus); end
        load_both(8'h99);
        plus = 1'b1; cyc(); plus = 1'b0;
        total++; if (w_count !== 8'h00 || w_plus !== 1'b1 || w_zero !== 1'b1) begin bad++; $display("FAIL carry_wrap count=%h plus=%b zero=%b exp=00/1/1", w_count, w_plus, w_zero); end
        cyc();
        total++; if (w_plus !== 1'b0 || w_count !== 8'h00) begin bad++; $display("FAIL carry_pulse_len plus=%b count=%h exp=0/00", w_plus, w_count); end
    endtask

    task automatic test_borrow();
        load_both(8'h00);
        minus = 1'b1; cyc(); minus = 1'b0;
        total++; if (w_count !== 8'h99 || w_minus !== 1'b1 || w_max !== 1'b1) begin bad++; $display("FAIL borrow_wrap count=%h minus=%b max=%b exp=99/1/1", w_count, w_minus, w_max); end
        cyc();
        total++; if (w_minus !== 1'b0) begin bad++; $display("FAIL borrow_pulse_len minus=%b exp=0", w_minus); end
        load_both(8'h10);
        minus = 1'b1; cyc(); minus = 1'b0;
        total++; if (w_count !== 8'h09 || w_minus !== 1'b0) begin bad++; $display("FAIL borrow_10 count=%h minus=%b exp=09/0", w_count, w_minus); end
    endtask

    task automatic test_saturate();
        load_both(8'h99);
        plus = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++; if (s_count !== 8'h99 || s_plus !== 1'b1 || s_max !== 1'b1) begin bad++; $display("FAIL sat_up_%0d count=%h plus=%b exp=99/1", i, s_count, s_plus); end
        end
        plus = 1'b0;
        total++; if (w_count !== 8'h02) begin bad++; $display("FAIL sat_wrap_twin count=%h exp=02", w_count); end
        load_both(8'h00);
        minus = 1'b1; cyc(); minus = 1'b0;
        total++; if (s_count !== 8'h00 || s_minus !== 1'b1 || s_zero !== 1'b1) begin bad++; $display("FAIL sat_down count=%h minus=%b exp=00/1", s_count, s_minus); end
        cyc();
        total++; if (s_minus !== 1'b0) begin bad++; $display("FAIL sat_down_len minus=%b exp=0", s_minus); end
    endtask

    task automatic test_conflict();
        load_both(8'h42);
        plus = 1'b1; minus = 1'b1; cyc(); plus = 1'b0; minus = 1'b0;
        total++; if (w_count !== 8'h42 || w_plus !== 1'b0 || w_minus !== 1'b0) begin bad++; $display("FAIL conflict count=%h plus=%b minus=%b exp=42/0/0", w_count, w_plus, w_minus); end
        load_both(8'h99);
        plus = 1'b1; load = 1'b1; cnt_in = 8'h05; cyc(); plus = 1'b0; load = 1'b0;
        total++; if (w_count !== 8'h05 || w_plus !== 1'b0 || s_plus !== 1'b0) begin bad++; $display("FAIL load_priority count=%h plus=%b splus=%b exp=05/0/0", w_count, w_plus, s_plus); end
    endtask

    task automatic test_illegal();
        load_both(8'hA3);
        total++; if (w_count !== 8'h93 || w_err !== 1'b1) begin bad++; $display("FAIL illegal_a3 count=%h err=%b exp=93/1", w_count, w_err); end
        cyc();
        total++; if (w_err !== 1'b0) begin bad++; $display("FAIL illegal_len err=%b exp=0", w_err); end
        load_both(8'hFF);
        total++; if (w_count !== 8'h99 || w_err !== 1'b1 || w_plus !== 1'b0) begin bad++; $display("FAIL illegal_ff count=%h err=%b exp=99/1", w_count, w_err); end
        load_both(8'h58);
        total++; if (w_err !== 1'b0) begin bad++; $display("FAIL legal_load err=%b exp=0", w_err); end
    endtask

    task automatic test_radix6();
        r_load = 1'b1; r_cnt_in = 9'o555; cyc(); r_load = 1'b0;
        total++; if (r_max !== 1'b1 || r_err !== 1'b0) begin bad++; $display("FAIL r6_load max=%b err=%b exp=1/0", r_max, r_err); end
        r_plus = 1'b1; cyc(); r_plus = 1'b0;
        total++; if (r_count !== 9'o000 || r_plus_o !== 1'b1 || r_zero !== 1'b1) begin bad++; $display("FAIL r6_wrap count=%o plus=%b exp=000/1", r_count, r_plus_o); end
        r_load = 1'b1; r_cnt_in = 9'o055; cyc(); r_load = 1'b0;
        r_plus = 1'b1; cyc(); r_plus = 1'b0;
        total++; if (r_count !== 9'o100 || r_plus_o !== 1'b0) begin bad++; $display("FAIL r6_ripple count=%o plus=%b exp=100/0", r_count, r_plus_o); end
        r_minus = 1'b1; cyc(); r_minus = 1'b0;
        total++; if (r_count !== 9'o055) begin bad++; $display("FAIL r6_borrow count=%o exp=055", r_count); end
        r_load = 1'b1; r_cnt_in = 9'o706; cyc(); r_load = 1'b0;
        total++; if (r_count !== 9'o505 || r_err !== 1'b1) begin bad++; $display("FAIL r6_illegal count=%o err=%b exp=505/1", r_count, r_err); end
    endtask

    task automatic test_back_to_back();
        int n_plus;
        n_plus = 0;
        load_both(8'h95);
        plus = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (w_plus) n_plus++;
        end
        plus = 1'b0;
        total++; if (w_count !== 8'h07) begin bad++; $display("FAIL b2b_count count=%h exp=07", w_count); end
        total++; if (n_plus !== 1) begin bad++; $display("FAIL b2b_pulses got=%0d exp=1", n_plus); end
        total++; if (s_count !== 8'h99) begin bad++; $display("FAIL b2b_sat count=%h exp=99", s_count); end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_borrow();
        test_saturate();
        test_conflict();
        test_illegal();
        test_radix6();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
